cmp_share_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one WIDTH-bit magnitude comparator among NREQ requesters. Each requester presents an operand pair (A, B) with a request line. The block grants one requester at a time, latches its operands, and runs the shared comparator. It returns registered gt/lt/eq flags with a one-cycle done pulse tagged with the requester index. It sits between the compare-issuing control units and the single combinational comparator datapath, which is instantiated inside this block.

---
 rtl/cmp_share_arbiter_if.sv | 28 ++
 rtl/cmp_share_arbiter.sv | 113 +++++++++++
 tb/tb_cmp_share_arbiter.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cmp_share_arbiter_if.sv
// Request/result bundle between the compare-issuing units and the shared comparator block.
// The master is the requester side and the slave is the arbiter.
interface cmp_share_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 4,
  parameter int IDW   = $clog2(NREQ)
);
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] a_in;
  logic [NREQ*WIDTH-1:0] b_in;
  logic [NREQ-1:0]       gnt;
  logic                  busy;
  logic                  done;
  logic [IDW-1:0]        done_id;
  logic                  a_gt_b;
  logic                  a_lt_b;
  logic                  a_eq_b;

  modport master (
    output req, a_in, b_in,
    input  gnt, busy, done, done_id, a_gt_b, a_lt_b, a_eq_b
  );

  modport slave (
    input  req, a_in, b_in,
    output gnt, busy, done, done_id, a_gt_b, a_lt_b, a_eq_b
  );
endinterface

// File: rtl/cmp_share_arbiter.sv
// Round-robin share of one unsigned comparator among NREQ requesters; 3 cycles per compare.
// Grant at edge k, done pulse after edge k+1; requesters hold req (level) until their done.
module cmp_share_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 4,
  parameter int IDW   = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  cmp_share_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, CMP, DONE} state_t;

  state_t           state, state_nxt;
  logic [NREQ-1:0]  gnt_q, gnt_nxt;
  logic [IDW-1:0]   ptr_q, ptr_nxt;
  logic [IDW-1:0]   cur_q, cur_nxt;
  logic [IDW-1:0]   done_id_q, done_id_nxt;
  logic [WIDTH-1:0] op_a_q, op_a_nxt;
  logic [WIDTH-1:0] op_b_q, op_b_nxt;
  logic             done_q, done_nxt;
  logic [2:0]       flags_q, flags_nxt;  // {gt, lt, eq}
  logic [IDW-1:0]   winner;
  logic             found;
  logic             cmp_gt, cmp_lt, cmp_eq;

  // Shared comparator works on the operands captured at grant time.
  assign cmp_eq = (op_a_q == op_b_q);
  assign cmp_gt = (op_a_q > op_b_q);
  assign cmp_lt = (op_a_q < op_b_q);

  // Search starts just past the last served requester; NREQ is a power of two, so IDW-bit add wraps.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    for (int i = 1; i <= NREQ; i++) begin
      if (!found && bus.req[ptr_q + IDW'(i)]) begin
        winner = ptr_q + IDW'(i);
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    gnt_nxt     = gnt_q;
    ptr_nxt     = ptr_q;
    cur_nxt     = cur_q;
    done_id_nxt = done_id_q;
    op_a_nxt    = op_a_q;
    op_b_nxt    = op_b_q;
    done_nxt    = 1'b0;
    flags_nxt   = flags_q;
    case (state)
      IDLE: begin
        if (found) begin
          op_a_nxt  = bus.a_in[winner*WIDTH +: WIDTH];
          op_b_nxt  = bus.b_in[winner*WIDTH +: WIDTH];
          gnt_nxt   = NREQ'(1) << winner;
          cur_nxt   = winner;
          state_nxt = CMP;
        end
      end
      CMP: begin
        flags_nxt   = {cmp_gt, cmp_lt, cmp_eq};
        done_id_nxt = cur_q;
        done_nxt    = 1'b1;
        state_nxt   = DONE;
      end
      DONE: begin
        gnt_nxt   = '0;
        ptr_nxt   = cur_q;
        state_nxt = IDLE;
      end
      default: begin
        gnt_nxt   = '0;
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      gnt_q     <= '0;
      ptr_q     <= IDW'(NREQ - 1);
      cur_q     <= '0;
      done_id_q <= '0;
      op_a_q    <= '0;
      op_b_q    <= '0;
      done_q    <= 1'b0;
      flags_q   <= 3'b000;
    end else begin
      state     <= state_nxt;
      gnt_q     <= gnt_nxt;
      ptr_q     <= ptr_nxt;
      cur_q     <= cur_nxt;
      done_id_q <= done_id_nxt;
      op_a_q    <= op_a_nxt;
      op_b_q    <= op_b_nxt;
      done_q    <= done_nxt;
      flags_q   <= flags_nxt;
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.busy    = (state != IDLE);
  assign bus.done    = done_q;
  assign bus.done_id = done_id_q;
  assign bus.a_gt_b  = flags_q[2];
  assign bus.a_lt_b  = flags_q[1];
  assign bus.a_eq_b  = flags_q[0];
endmodule

// File: tb/tb_cmp_share_arbiter.sv
// Bench for cmp_share_arbiter: transaction-level model checked every cycle plus directed literal checks.
module tb_cmp_share_arbiter;
  localparam int NREQ  = 4;
  localparam int WIDTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cmp_share_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus();
  cmp_share_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Model: an operation is either absent (age -1), just granted (age 0) or returning (age 1).
  bit              started = 1'b0;
  int              m_age, m_ptr, m_cur, m_opa, m_opb, m_id, m_diff;
  logic [NREQ-1:0] m_gnt;
  bit              m_done, m_gt, m_lt, m_eq;
  bit              prev_done = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d required %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      started = 1'b1;
      m_age = -1; m_ptr = NREQ - 1; m_cur = 0; m_gnt = '0;
      m_done = 1'b0; m_id = 0; m_gt = 1'b0; m_lt = 1'b0; m_eq = 1'b0;
    end else if (started) begin
      if (m_age < 0) begin
        if (bus.req != '0) begin
          for (int s = 1; s <= NREQ; s++) begin
            if (bus.req[(m_ptr + s) % NREQ]) begin
              m_cur = (m_ptr + s) % NREQ;
              break;
            end
          end
          m_opa = int'(bus.a_in[m_cur*WIDTH +: WIDTH]);
          m_opb = int'(bus.b_in[m_cur*WIDTH +: WIDTH]);
          m_gnt = '0;
          m_gnt[m_cur] = 1'b1;
          m_age = 0;
        end
      end else if (m_age == 0) begin
        m_diff = m_opa - m_opb;
        m_gt = (m_diff > 0); m_lt = (m_diff < 0); m_eq = (m_diff == 0);
        m_done = 1'b1; m_id = m_cur; m_age = 1;
      end else begin
        m_done = 1'b0; m_gnt = '0; m_ptr = m_cur; m_age = -1;
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("gnt", int'(bus.gnt), int'(m_gnt));
      chk("busy", int'(bus.busy), int'(m_age >= 0));
      chk("done", int'(bus.done), int'(m_done));
      chk("done_id", int'(bus.done_id), m_id);
      chk("flags", int'({bus.a_gt_b, bus.a_lt_b, bus.a_eq_b}), int'({m_gt, m_lt, m_eq}));
      chk("gnt_onehot0", int'($onehot0(bus.gnt)), 1);
      chk("done_twice", int'(prev_done & bus.done), 0);
      prev_done = bus.done;
    end
  end

  task automatic set_op(input int i, input int a, input int b);
    bus.a_in[i*WIDTH +: WIDTH] = WIDTH'(a);
    bus.b_in[i*WIDTH +: WIDTH] = WIDTH'(b);
  endtask

  task automatic after_edge();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_done(output int id, output int flg, output int at);
    bit got = 1'b0;
    id = -1; flg = -1; at = 0;
    for (int n = 0; n < 40 && !got; n++) begin
      @(negedge clk);
      if (bus.done) begin
        got = 1'b1;
        id  = int'(bus.done_id);
        flg = int'({bus.a_gt_b, bus.a_lt_b, bus.a_eq_b});
        at  = cyc;
      end
    end
    if (!got) chk("done_timeout", 0, 1);
  endtask

  task automatic wait_gnt(input int idx, output int at);
    bit got = 1'b0;
    at = 0;
    for (int n = 0; n < 40 && !got; n++) begin
      @(negedge clk);
      if (bus.gnt[idx]) begin
        got = 1'b1;
        at  = cyc;
      end
    end
    if (!got) chk("gnt_timeout", 0, 1);
  endtask

  task automatic run_one(input int idx, input int a, input int b, input int exp_flg, input string nm);
    int id, flg, at;
    set_op(idx, a, b);
    bus.req = NREQ'(1) << idx;
    wait_done(id, flg, at);
    chk({nm, "_id"}, id, idx);
    chk({nm, "_flags"}, flg, exp_flg);
    chk({nm, "_one_flag"}, $countones(flg[2:0]), 1);
    after_edge();
    bus.req = '0;
  endtask

  int ta[5] = '{8, 12, 2, 12, 15};
  int tb_[5] = '{2, 10, 3, 12, 0};
  int te[5] = '{4, 4, 2, 1, 4};

  initial begin
    int id, flg, at, g, last;
    bus.req = '0;
    bus.a_in = '0;
    bus.b_in = '0;
    rst = 1'b1;

    // Reset, then a single request from requester 0.
    @(posedge clk);
    @(negedge clk);
    chk("rst_gnt", int'(bus.gnt), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_done_id", int'(bus.done_id), 0);
    chk("rst_flags", int'({bus.a_gt_b, bus.a_lt_b, bus.a_eq_b}), 0);
    after_edge();
    rst = 1'b0;
    set_op(0, 0, 2);
    bus.req = 4'b0001;
    wait_gnt(0, g);
    chk("t1_gnt", int'(bus.gnt), 1);
    chk("t1_done_early", int'(bus.done), 0);
    wait_done(id, flg, at);
    chk("t1_latency", at - g, 1);
    chk("t1_id", id, 0);
    chk("t1_flags", flg, 3'b010);
    after_edge();
    bus.req = '0;

    // Requester 2 through every comparison outcome.
    for (int k = 0; k < 5; k++) run_one(2, ta[k], tb_[k], te[k], "r2");

    // Round robin: serve requester 3 so rotation starts from 0.
    run_one(3, 1, 1, 3'b001, "pre_rr");
    for (int i = 0; i < NREQ; i++) set_op(i, i, 2);
    bus.req = 4'b1111;
    last = 0;
    for (int k = 0; k < 12; k++) begin
      wait_done(id, flg, at);
      chk("rr_id", id, k % NREQ);
      if (k > 0) chk("rr_spacing", at - last, 3);
      last = at;
    end
    after_edge();
    bus.req = '0;

    // Operands and req change while the compare is in flight.
    set_op(1, 5, 9);
    bus.req = 4'b0010;
    wait_gnt(1, g);
    set_op(1, 15, 0);
    bus.req = '0;
    wait_done(id, flg, at);
    chk("stab_id", id, 1);
    chk("stab_flags", flg, 3'b010);
    after_edge();

    // Idle requesters are skipped: 3 then 0.
    set_op(3, 7, 7);
    set_op(0, 1, 9);
    bus.req = 4'b1001;
    wait_done(id, flg, at);
    chk("skip_id0", id, 3);
    chk("skip_flags0", flg, 3'b001);
    wait_done(id, flg, at);
    chk("skip_id1", id, 0);
    chk("skip_flags1", flg, 3'b010);
    after_edge();
    bus.req = '0;

    // Reset during CMP discards the operation.
    set_op(2, 9, 1);
    bus.req = 4'b0100;
    wait_gnt(2, g);
    rst = 1'b1;
    @(negedge clk);
    chk("mrst_done", int'(bus.done), 0);
    chk("mrst_gnt", int'(bus.gnt), 0);
    chk("mrst_busy", int'(bus.busy), 0);
    chk("mrst_done_id", int'(bus.done_id), 0);
    chk("mrst_flags", int'({bus.a_gt_b, bus.a_lt_b, bus.a_eq_b}), 0);
    rst = 1'b0;
    wait_done(id, flg, at);
    chk("mrst_after_id", id, 2);
    chk("mrst_after_flags", flg, 3'b100);
    after_edge();
    bus.req = '0;

    // After reset, requester 0 beats requester 2.
    @(negedge clk);
    rst = 1'b1;
    set_op(0, 3, 3);
    set_op(2, 0, 15);
    bus.req = 4'b0101;
    @(negedge clk);
    rst = 1'b0;
    wait_done(id, flg, at);
    chk("rst_pair_id0", id, 0);
    chk("rst_pair_flags0", flg, 3'b001);
    wait_done(id, flg, at);
    chk("rst_pair_id1", id, 2);
    chk("rst_pair_flags1", flg, 3'b010);
    after_edge();
    bus.req = '0;

    repeat (4) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual timeout required completion");
    $fatal(1, "watchdog");
  end
endmodule
